// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer that shares one single-byte I2C master among N_REQ requesters.
// It issues one transaction at a time, waits for completion or timeout, then returns the response.
module i2c_txn_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16383
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_ack_err,
    output logic                 rsp_timeout,
    output logic                 m_newd,
    output logic                 m_op,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_din,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_dout
);
    // state     | meaning
    // IDLE      | wait for a request while the master is free, pick winner
    // ISSUE     | grant + start strobe to the master (one cycle)
    // WAIT_DONE | wait for m_done, abort when the timeout counter expires
    // RESP      | one-cycle response pulse to the winner, grant dropped

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_ack_err_q, rsp_ack_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              m_newd_q, m_newd_d;
    logic              m_op_q, m_op_d;
    logic [6:0]        m_addr_q, m_addr_d;
    logic [7:0]        m_din_q, m_din_d;
    logic              m_abort_q, m_abort_d;

    logic [IW-1:0]     pick_idx;
    logic [IW:0]       rr_sum;

    // Scan from farthest to nearest after the last winner so the nearest asserted index wins.
    always_comb begin
        pick_idx = last_q;
        rr_sum   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_sum = {1'b0, last_q} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(N_REQ)) begin
                rr_sum = rr_sum - (IW+1)'(N_REQ);
            end
            if (req[rr_sum[IW-1:0]]) begin
                pick_idx = rr_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        win_d         = win_q;
        gnt_d         = gnt_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_ack_err_d = rsp_ack_err_q;
        rsp_timeout_d = rsp_timeout_q;
        m_newd_d      = 1'b0;
        m_op_d        = m_op_q;
        m_addr_d      = m_addr_q;
        m_din_d       = m_din_q;
        m_abort_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((|req) && !m_busy) begin
                    win_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    m_newd_d        = 1'b1;
                    m_op_d          = req_rw[pick_idx];
                    m_addr_d        = req_addr[7*pick_idx +: 7];
                    m_din_d         = req_wdata[8*pick_idx +: 8];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes precedence over a timeout landing in the same cycle.
                if (m_done) begin
                    rsp_rdata_d   = m_op_q ? m_dout : 8'h00;
                    rsp_ack_err_d = m_ack_err;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = gnt_q;
                    gnt_d         = '0;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    m_abort_d     = 1'b1;
                    rsp_rdata_d   = 8'h00;
                    rsp_ack_err_d = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = gnt_q;
                    gnt_d         = '0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                last_d  = win_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= IW'(N_REQ - 1);
            win_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_ack_err_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            m_newd_q      <= 1'b0;
            m_op_q        <= 1'b0;
            m_addr_q      <= '0;
            m_din_q       <= '0;
            m_abort_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_ack_err_q <= rsp_ack_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            m_newd_q      <= m_newd_d;
            m_op_q        <= m_op_d;
            m_addr_q      <= m_addr_d;
            m_din_q       <= m_din_d;
            m_abort_q     <= m_abort_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ack_err = rsp_ack_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_newd      = m_newd_q;
    assign m_op        = m_op_q;
    assign m_addr      = m_addr_q;
    assign m_din       = m_din_q;
    assign m_abort     = m_abort_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: stimulus pushes expected issues/responses,
// a negedge monitor pops and compares whenever the DUT strobes m_newd or rsp_valid.
module tb_i2c_txn_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 100;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req = '0;
    logic [7*N_REQ-1:0]   req_addr = '0;
    logic [N_REQ-1:0]     req_rw = '0;
    logic [8*N_REQ-1:0]   req_wdata = '0;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     rsp_valid;
    logic [7:0]           rsp_rdata;
    logic                 rsp_ack_err;
    logic                 rsp_timeout;
    logic                 m_newd;
    logic                 m_op;
    logic [6:0]           m_addr;
    logic [7:0]           m_din;
    logic                 m_abort;
    logic                 m_busy = 1'b0;
    logic                 m_done = 1'b0;
    logic                 m_ack_err = 1'b0;
    logic [7:0]           m_dout = '0;

    i2c_txn_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout), .m_newd(m_newd), .m_op(m_op),
        .m_addr(m_addr), .m_din(m_din), .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
        .m_ack_err(m_ack_err), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [6:0]       addr;
        logic             op;
        logic [7:0]       din;
    } iss_t;

    typedef struct packed {
        logic [N_REQ-1:0] valid;
        logic [7:0]       rdata;
        logic             ack;
        logic             to;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {8'h0, gnt, rsp_valid, rsp_ack_err, rsp_timeout, m_newd, m_op, m_abort,
                (|m_addr), (|m_din), (|rsp_rdata)};
    endfunction

    // Monitor: compare every strobe against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
            if (m_newd) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", 32'(m_addr), 32'hFFFF_FFFF);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("iss_gnt", 32'(gnt), 32'(e.gnt));
                    check("iss_addr", 32'(m_addr), 32'(e.addr));
                    check("iss_op", 32'(m_op), 32'(e.op));
                    check("iss_din", 32'(m_din), 32'(e.din));
                end
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'hFFFF_FFFF);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(r.valid));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                    check("rsp_ack_err", 32'(rsp_ack_err), 32'(r.ack));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
                    check("rsp_gnt_cleared", 32'(gnt), 32'd0);
                end
            end
        end
    end

    task automatic push_iss(input int idx, input logic [6:0] addr, input logic rw,
                            input logic [7:0] wd);
        iss_t e;
        e.gnt  = N_REQ'(1) << idx;
        e.addr = addr;
        e.op   = rw;
        e.din  = wd;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input int idx, input logic [7:0] rdata, input logic ack,
                            input logic to);
        rsp_t r;
        r.valid = N_REQ'(1) << idx;
        r.rdata = rdata;
        r.ack   = ack;
        r.to    = to;
        rsp_q.push_back(r);
    endtask

    // Waits (checking the current cycle first) for rsp_valid; returns cycles waited.
    task automatic wait_rsp(output int c);
        for (c = 0; c < TIMEOUT + 20; c++) begin
            if (|rsp_valid) break;
            @(negedge clk);
        end
        check("rsp_wait_bound", 32'(c < TIMEOUT + 20), 32'd1);
    endtask

    task automatic wait_newd(output int c);
        for (c = 0; c < 12; c++) begin
            if (m_newd) break;
            @(negedge clk);
        end
        check("newd_wait_bound", 32'(c < 12), 32'd1);
    endtask

    // delay < 0: master never finishes and the DUT must abort.
    task automatic do_txn(input int idx, input logic [6:0] addr, input logic rw,
                          input logic [7:0] wd, input int delay, input logic [7:0] dout,
                          input logic ack, input logic [7:0] exp_rdata, input logic exp_ack,
                          input logic exp_to);
        int c;
        int aborts;
        push_iss(idx, addr, rw, wd);
        push_rsp(idx, exp_rdata, exp_ack, exp_to);
        req_addr[7*idx +: 7]  = addr;
        req_rw[idx]           = rw;
        req_wdata[8*idx +: 8] = wd;
        req[idx]              = 1'b1;
        @(negedge clk);
        wait_newd(c);
        check("issue_latency", 32'(c), 32'd0);
        m_busy = 1'b1;
        if (delay >= 0) begin
            aborts = 0;
            repeat (delay) begin
                @(negedge clk);
                if (m_abort) aborts++;
            end
            m_done = 1'b1; m_dout = dout; m_ack_err = ack;
            @(negedge clk);
            m_done = 1'b0; m_dout = 8'h00; m_ack_err = 1'b0; m_busy = 1'b0;
            if (m_abort) aborts++;
            check("no_abort", 32'(aborts), 32'd0);
        end else begin
            for (c = 1; c <= TIMEOUT + 5; c++) begin
                @(negedge clk);
                if (m_abort) break;
            end
            check("abort_delay", 32'(c), 32'(TIMEOUT));
            m_busy = 1'b0;
        end
        wait_rsp(c);
        req[idx] = 1'b0;
        @(negedge clk);
        check("abort_one_cycle", 32'(m_abort), 32'd0);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset with all four requesters asserted from the start.
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[7*i +: 7]  = 7'(8'h10 + i);
            req_wdata[8*i +: 8] = 8'(8'h40 + i);
        end
        req_rw = '0;
        req    = '1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);

        // Round robin with requests held continuously: 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            push_iss(t % 4, 7'(8'h10 + t % 4), 1'b0, 8'(8'h40 + t % 4));
            push_rsp(t % 4, 8'h00, 1'b0, 1'b0);
        end
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            wait_newd(c);
            if (t > 0) check("turnaround", 32'(c), 32'd1);
            m_busy = 1'b1;
            repeat (5) @(negedge clk);
            m_done = 1'b1; m_dout = 8'h5A;
            @(negedge clk);
            m_done = 1'b0; m_dout = 8'h00; m_busy = 1'b0;
            wait_rsp(c);
            if (t == 4) req = '0;
        end
        repeat (2) @(negedge clk);

        // Write with garbage m_dout: rdata must read back 0.
        do_txn(0, 7'h20, 1'b0, 8'hA5, 50, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
        // Read returning data.
        do_txn(2, 7'h51, 1'b1, 8'h00, 10, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);

        // m_done while idle must be ignored.
        m_done = 1'b1; m_dout = 8'hFF;
        @(negedge clk);
        m_done = 1'b0; m_dout = 8'h00;
        c = 0;
        repeat (4) begin
            @(negedge clk);
            if (|rsp_valid || m_newd) c++;
        end
        check("idle_done_ignored", 32'(c), 32'd0);

        // Master never completes -> abort and timeout response.
        do_txn(1, 7'h2B, 1'b0, 8'h66, -1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        // Done with NACK on the exact timeout cycle: done wins.
        do_txn(3, 7'h6E, 1'b1, 8'h00, TIMEOUT - 1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0);
        // One cycle earlier: plain completion with NACK on a write.
        do_txn(0, 7'h01, 1'b0, 8'h0F, TIMEOUT - 2, 8'h99, 1'b1, 8'h00, 1'b1, 1'b0);

        // Reset during WAIT_DONE drops the transaction silently.
        push_iss(2, 7'h33, 1'b1, 8'h00);
        req_addr[7*2 +: 7] = 7'h33; req_rw[2] = 1'b1; req[2] = 1'b1;
        @(negedge clk);
        wait_newd(c);
        m_busy = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outputs(), 32'd0);
        req = '0; m_busy = 1'b0;
        @(negedge clk);
        check("reset_hold_outputs", all_outputs(), 32'd0);
        req_addr[7*0 +: 7] = 7'h0A; req_rw[0] = 1'b0; req_wdata[8*0 +: 8] = 8'h11;
        req_addr[7*3 +: 7] = 7'h7F; req_rw[3] = 1'b0; req_wdata[8*3 +: 8] = 8'h22;
        req = 4'b1001;
        push_iss(0, 7'h0A, 1'b0, 8'h11);
        push_rsp(0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_newd(c);
        check("post_reset_gnt", 32'(gnt), 32'b0001);
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_busy = 1'b0;
        wait_rsp(c);
        req[0] = 1'b0;
        @(negedge clk);
        do_txn(3, 7'h7F, 1'b0, 8'h22, 4, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("iss_queue_drained", 32'(iss_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
